// File: rtl/simple_lfsr.sv
// Left-shifting register that shifts in either a serial data bit or the
// Fibonacci feedback of its tapped bits. Used as a seedable pattern generator.
module simple_lfsr #(
   parameter int                LENGTH = 8,
   parameter logic [LENGTH-1:0] TAPS   = LENGTH'(8'hB8),
   parameter logic [LENGTH-1:0] SEED   = LENGTH'(1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              d,
   input  logic              fb,
   output logic [LENGTH-1:0] state
);

   if (LENGTH < 2 || LENGTH > 64) begin : g_bad_length
      $error("simple_lfsr: LENGTH must be in 2..64");
   end

   logic in_bit;

   // An all-zero register would otherwise lock up in feedback mode, so force a 1.
   always_comb begin
      // NOTE: default assigned first so every path drives in_bit and no latch is inferred.
      in_bit = d;
      if (fb) begin
         if (state == '0) begin
            in_bit = 1'b1;
         end else begin
            in_bit = ^(state & TAPS);
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignment so every flop samples the pre-edge state.
      if (rst) begin
         state <= SEED;
      end else begin
         state <= {state[LENGTH-2:0], in_bit};
      end
   end

endmodule

// File: tb/tb_simple_lfsr.sv
// Self-checking bench for simple_lfsr with default parameters: directed vector
// table, a full-period walk, and randomized stimulus against a reference model.
module tb_simple_lfsr;

   localparam int         LENGTH = 8;
   localparam logic [7:0] TAPS   = 8'hB8;
   localparam logic [7:0] SEED   = 8'h01;

   logic       clk = 1'b0;
   logic       rst;
   logic       d;
   logic       fb;
   logic [7:0] state;

   int checks = 0;
   int errors = 0;

   simple_lfsr dut (
      .clk  (clk),
      .rst  (rst),
      .d    (d),
      .fb   (fb),
      .state(state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       d;
      logic       fb;
      logic [7:0] exp;
      string      name;
   } vec_t;

   // Reference: next value from the behavioural rules, using plain arithmetic.
   function automatic logic [7:0] model_next(logic [7:0] s, logic r, logic din, logic f);
      int nb;
      if (r) return SEED;
      if (!f)          nb = int'(din);
      else if (s == 0) nb = 1;
      else             nb = $countones(s & TAPS) % 2;
      return 8'((int'(s) * 2 + nb) % 256);
   endfunction

   task automatic check(string name, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive on the falling edge, sample 1 time unit after the rising edge.
   task automatic step(logic r, logic din, logic f);
      @(negedge clk);
      rst = r;
      d   = din;
      fb  = f;
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[$];

   initial begin
      logic [7:0] model;
      bit         seen [256];
      int         dups;

      rst = 1'b0;
      d   = 1'b0;
      fb  = 1'b0;

      vecs = '{
         '{1, 0, 0, 8'h01, "reset"},
         '{1, 1, 1, 8'h01, "reset_hold_fb"},
         '{1, 1, 0, 8'h01, "reset_hold_d"},
         '{0, 1, 0, 8'h03, "load1"},
         '{0, 1, 0, 8'h07, "load2"},
         '{0, 1, 0, 8'h0F, "load3"},
         '{0, 0, 0, 8'h1E, "load0_1"},
         '{0, 0, 0, 8'h3C, "load0_2"},
         '{1, 0, 0, 8'h01, "reset2"},
         '{0, 0, 1, 8'h02, "lfsr1"},
         '{0, 0, 1, 8'h04, "lfsr2"},
         '{0, 1, 1, 8'h08, "lfsr3"},
         '{0, 0, 1, 8'h11, "lfsr4"},
         '{0, 1, 1, 8'h23, "lfsr5"},
         '{1, 0, 1, 8'h01, "midrun_reset"},
         '{0, 0, 1, 8'h02, "restart"},
         '{0, 0, 1, 8'h04, "lfsr_b2"},
         '{0, 0, 1, 8'h08, "lfsr_b3"},
         '{0, 0, 1, 8'h11, "lfsr_b4"},
         '{0, 0, 1, 8'h23, "lfsr_b5"},
         '{0, 0, 1, 8'h47, "lfsr_b6"},
         '{0, 1, 0, 8'h8F, "mode_to_serial"},
         '{0, 0, 1, 8'h1E, "mode_to_lfsr"},
         '{0, 0, 0, 8'h3C, "zero1"},
         '{0, 0, 0, 8'h78, "zero2"},
         '{0, 0, 0, 8'hF0, "zero3"},
         '{0, 0, 0, 8'hE0, "zero4"},
         '{0, 0, 0, 8'hC0, "zero5"},
         '{0, 0, 0, 8'h80, "zero6"},
         '{0, 0, 0, 8'h00, "zero7"},
         '{0, 0, 0, 8'h00, "zero8"},
         '{0, 0, 1, 8'h01, "lockup_guard"},
         '{0, 0, 1, 8'h02, "after_guard"},
         '{0, 0, 1, 8'h04, "after_guard2"}
      };

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].d, vecs[i].fb);
         check(vecs[i].name, state, vecs[i].exp);
      end

      // Full period: 255 feedback edges from SEED, no repeats, back to SEED.
      step(1, 0, 0);
      check("period_reset", state, SEED);
      foreach (seen[i]) seen[i] = 1'b0;
      dups = 0;
      for (int i = 0; i < 255; i++) begin
         step(0, $urandom_range(0, 1), 1);
         if (seen[state]) dups++;
         seen[state] = 1'b1;
      end
      check("period_wrap", state, SEED);
      check("period_dups", 8'(dups), 8'h00);

      // Randomized mode/data/reset traffic against the reference model.
      model = state;
      for (int i = 0; i < 2000; i++) begin
         logic r, din, f;
         r   = ($urandom_range(0, 31) == 0);
         din = $urandom_range(0, 1);
         f   = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 199) == 0) begin
            for (int k = 0; k < 8; k++) begin
               step(0, 0, 0);
               model = model_next(model, 0, 0, 0);
            end
            check("rand_zero_fill", state, model);
         end
         step(r, din, f);
         model = model_next(model, r, din, f);
         check("rand", state, model);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/simple_lfsr.md
Name: simple_lfsr

Overview:
- Parameterised shift register with two modes, selected every cycle by `fb`:
  - Serial-load mode: external bit `d` shifts into the register.
  - Fibonacci LFSR mode: XOR of tapped register bits shifts in.
- Used as a seedable pseudo-random / test-pattern generator.
- The full register is always visible on `state`.

Parameters:
- LENGTH, default 8: register width in bits. Legal range 2..64.
- TAPS, default 8'hB8 (LENGTH bits wide): feedback tap mask. Bit i set means state[i] enters the feedback XOR. The default implements x^8+x^6+x^5+x^4+1, which is maximal length, period 255.
- SEED, default 1 (LENGTH bits wide): value loaded on reset.

Ports:
- clk    input   1        clock; all state changes on the rising edge.
- rst    input   1        synchronous, active-high reset.
- d      input   1        serial data input, used when fb=0.
- fb     input   1        mode select: 0 = shift in d, 1 = shift in feedback.
- state  output  LENGTH   current register contents, driven directly from flops.

Behaviour:
- Single clock domain. Reset is synchronous and active-high:
  - On a rising clk edge with rst=1, state <= SEED.
  - rst has priority over d and fb.
  - Before the first reset, state is undefined.
- Shift direction is left, toward the MSB. Each rising edge with rst=0:
  - state <= {state[LENGTH-2:0], in_bit}
  - state[LENGTH-1] is discarded.
- in_bit selection:
  - fb=0: in_bit = d.
  - fb=1: in_bit = XOR-reduce(state & TAPS).
  - Lock-up guard, fb=1 and state == 0: in_bit = 1. The register therefore never sticks at all-zeros.
- Latency:
  - state reflects the new value one cycle after the edge that samples d/fb.
  - No combinational path from d or fb to state.
- Mode switching is permitted on any cycle. The register contents carry over unchanged across a mode change; there is no flush or reload.
- Reset asserted mid-sequence: state returns to SEED on that edge, and the sequence restarts from SEED on the next non-reset edge.
- Period in fb=1 mode from any nonzero state, for a primitive TAPS polynomial: 2^LENGTH - 1. Behaviour with a non-primitive TAPS is well-defined by the equations above; period is not guaranteed.
- Widths:
  - TAPS and SEED are truncated or zero-extended to LENGTH.
  - TAPS = 0 in fb=1 mode shifts in constant 0, except when the guard forces 1 (state all-zero).
- No other outputs. No enable; the register advances on every non-reset cycle.

Test Plan:
- Reset: hold rst=1 for one edge with d=0, fb=0 -> state = 8'h01 (SEED), held while rst stays 1 regardless of d/fb.
- Serial load: after reset, fb=0, d=1 for 3 edges -> state 8'h03, 8'h07, 8'h0F. Then d=0 for 2 edges -> 8'h1E, 8'h3C.
- LFSR sequence: reset, then fb=1 -> successive states 8'h02, 04, 08, 11, 23, 47, 8E, 1C. After 255 edges state returns to 8'h01, and no value repeats within that window.
- Lock-up guard: fb=0, d=0 for 8 edges (state 8'h00), then fb=1 -> next state 8'h01, after which the maximal sequence continues.
- Mid-run reset: run fb=1 for 5 edges (state 8'h23), assert rst for one edge -> state 8'h01. Next edge with fb=1 -> 8'h02.
- Mode switch: from state 8'h47 with fb=1, set fb=0, d=1 -> 8'h8F. Set fb=1 again -> next in_bit = s7^s5^s4^s3 = 1^0^0^1 = 0 -> 8'h1E.
